// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-core data-memory arbiter.
//   arb_state_e : arbiter FSM states
//   AbortData   : read data returned to a core whose transaction timed out
//   CntWidth    : width of the per-transaction cycle counter
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StIssue    = 2'd1,
      StWaitResp = 2'd2
   } arb_state_e;

   localparam logic [31:0] AbortData = 32'hDEAD_BEEF;
   localparam int unsigned CntWidth  = 16;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant.
//   valid_i       : request valid vector (index 0 = core 0)
//   last_grant_i  : index of the core that owned the last finished transaction
//   grant_o       : winning index (only meaningful when grant_valid_o is set)
//   grant_valid_o : at least one request is valid
module rr_arb2 (
   input  logic [1:0] valid_i,
   input  logic       last_grant_i,
   output logic       grant_o,
   output logic       grant_valid_o
);

   always_comb begin
      grant_valid_o = |valid_i;
      // On a tie the core that did not go last wins; otherwise the lone requester.
      if (&valid_i) begin
         grant_o = ~last_grant_i;
      end else begin
         grant_o = valid_i[1];
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one data-memory port between two cores.
//   clk, reset                    : clock, synchronous active-high reset
//   req_valid_i/wen/addr/wdata/be : per-core request, held until req_yumi_o
//   req_yumi_o                    : one-hot accept, only in IDLE
//   resp_valid_o, resp_data_o     : one-cycle completion pulse and shared read data
//   mem_*_o, mem_yumi_i           : single outgoing memory request and its accept
//   mem_rvalid_i, mem_rdata_i     : memory read return
//   grant_o, busy_o, timeout_o    : current owner, FSM not idle, sticky abort flag
module mem_arbiter #(
   parameter int unsigned TIMEOUT_P = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req_valid_i,
   input  logic [1:0]       req_wen_i,
   input  logic [1:0][31:0] req_addr_i,
   input  logic [1:0][31:0] req_wdata_i,
   input  logic [1:0][3:0]  req_be_i,
   output logic [1:0]       req_yumi_o,
   output logic [1:0]       resp_valid_o,
   output logic [31:0]      resp_data_o,
   output logic             mem_valid_o,
   output logic             mem_wen_o,
   output logic [31:0]      mem_addr_o,
   output logic [31:0]      mem_wdata_o,
   output logic [3:0]       mem_be_o,
   input  logic             mem_yumi_i,
   input  logic             mem_rvalid_i,
   input  logic [31:0]      mem_rdata_i,
   output logic             grant_o,
   output logic             busy_o,
   output logic             timeout_o
);

   import mem_arbiter_pkg::*;

   // Abort fires on the edge where the counter would reach TIMEOUT_P.
   localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TIMEOUT_P - 1);

   arb_state_e          state_q, state_d;
   logic                last_grant_q, last_grant_d;
   logic                grant_q, grant_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic [1:0]          resp_valid_q, resp_valid_d;
   logic [31:0]         resp_data_q, resp_data_d;
   logic                timeout_q, timeout_d;

   logic                wen_q;
   logic [31:0]         addr_q, wdata_q;
   logic [3:0]          be_q;

   logic                arb_grant, arb_any;
   logic                accept, load, in_issue, busy;
   logic                complete, abort;
   logic [31:0]         done_data;

   rr_arb2 u_rr_arb2 (
      .valid_i       (req_valid_i),
      .last_grant_i  (last_grant_q),
      .grant_o       (arb_grant),
      .grant_valid_o (arb_any)
   );

   // Gated by reset so a request is never yumi'd on an edge that discards it.
   assign accept   = (state_q == StIdle) && arb_any && !reset;
   assign in_issue = (state_q == StIssue);
   assign busy     = (state_q != StIdle);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      cnt_d        = cnt_q;
      resp_valid_d = 2'b00;
      resp_data_d  = '0;
      timeout_d    = timeout_q;
      load         = 1'b0;
      complete     = 1'b0;
      abort        = 1'b0;
      done_data    = '0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               load    = 1'b1;
               grant_d = arb_grant;
               cnt_d   = '0;
               state_d = StIssue;
            end
         end
         StIssue: begin
            cnt_d = cnt_q + CntWidth'(1);
            if (mem_yumi_i) begin
               if (wen_q) begin
                  complete = 1'b1;
               end else if (mem_rvalid_i) begin
                  complete  = 1'b1;
                  done_data = mem_rdata_i;
               end else begin
                  state_d = StWaitResp;
               end
            end
         end
         StWaitResp: begin
            cnt_d = cnt_q + CntWidth'(1);
            if (mem_rvalid_i) begin
               complete  = 1'b1;
               done_data = mem_rdata_i;
            end
         end
         default: state_d = StIdle;
      endcase

      // A completion landing on the final cycle beats the abort.
      abort = busy && (cnt_q == TimeoutLast) && !complete;

      if (complete || abort) begin
         state_d               = StIdle;
         last_grant_d          = grant_q;
         resp_valid_d[grant_q] = 1'b1;
         resp_data_d           = abort ? AbortData : done_data;
      end
      if (abort) begin
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         cnt_q        <= '0;
         resp_valid_q <= 2'b00;
         resp_data_q  <= '0;
         timeout_q    <= 1'b0;
         wen_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         cnt_q        <= cnt_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         timeout_q    <= timeout_d;
         if (load) begin
            wen_q   <= req_wen_i[arb_grant];
            addr_q  <= req_addr_i[arb_grant];
            wdata_q <= req_wdata_i[arb_grant];
            be_q    <= req_be_i[arb_grant];
         end
      end
   end

   assign req_yumi_o   = accept ? (arb_grant ? 2'b10 : 2'b01) : 2'b00;
   assign resp_valid_o = resp_valid_q;
   assign resp_data_o  = resp_data_q;
   // Request fields are zeroed outside ISSUE so stale data never leaks onto the bus.
   assign mem_valid_o  = in_issue;
   assign mem_wen_o    = in_issue & wen_q;
   assign mem_addr_o   = in_issue ? addr_q : '0;
   assign mem_wdata_o  = in_issue ? wdata_q : '0;
   assign mem_be_o     = in_issue ? be_q : '0;
   assign grant_o      = grant_q;
   assign busy_o       = busy;
   assign timeout_o    = timeout_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_P, default 255: max cycles from entering ISSUE to completion before abort; legal 2..65535.
REQ-002 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port req_valid_i, input, 2: per-core request valid (index 0 = core 0).
REQ-005 SHALL have port req_wen_i, input, 2: per-core write enable (1 = write).
REQ-006 SHALL have port req_addr_i, input, 2x32 packed: per-core byte address.
REQ-007 SHALL have port req_wdata_i, input, 2x32 packed: per-core write data.
REQ-008 SHALL have port req_be_i, input, 2x4 packed: per-core byte enables.
REQ-009 SHALL have port req_yumi_o, output, 2: request accepted this cycle, at most one bit set.
REQ-010 SHALL have port resp_valid_o, output, 2: one-cycle completion pulse to the owning core.
REQ-011 SHALL have port resp_data_o, output, 32: read data, shared by both cores, qualified by resp_valid_o.
REQ-012 SHALL have port mem_valid_o, mem_wen_o, mem_addr_o, mem_wdata_o, mem_be_o, outputs, 1/1/32/32/4: single data-memory request.
REQ-013 SHALL have port mem_yumi_i, input, 1: memory accepted the request.
REQ-014 SHALL have port mem_rvalid_i, mem_rdata_i, inputs, 1/32: memory read return.
REQ-015 SHALL have port grant_o, output, 1: index of the current owner; busy_o, output, 1: state != IDLE.
REQ-016 SHALL have port timeout_o, output, 1: sticky abort flag, feeds the core's exception path.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE and WAIT_RESP.
REQ-018 In IDLE with any req_valid_i set, SHALL assert the winner's req_yumi_o combinationally in the same cycle, latch its fields, set grant_o and enter ISSUE.
REQ-019 Arbitration SHALL be round-robin: a single requester wins; if both are valid, the index != last_grant_r wins.
REQ-020 last_grant_r SHALL update only when a transaction completes or aborts.
REQ-021 req_yumi_o SHALL be 0 in every state except IDLE; requesters hold their fields stable while valid and not yumi'd.
REQ-022 In ISSUE, mem_valid_o SHALL be 1 with the latched fields, held stable until mem_yumi_i.
REQ-023 On mem_yumi_i for a write, SHALL pulse resp_valid_o[grant] next cycle with resp_data_o = 0 and return to IDLE.
REQ-024 On mem_yumi_i for a read, SHALL enter WAIT_RESP.
REQ-025 If mem_rvalid_i coincides with mem_yumi_i for a read, SHALL complete directly without visiting WAIT_RESP.
REQ-026 In WAIT_RESP, on mem_rvalid_i SHALL register mem_rdata_i, pulse resp_valid_o[grant] next cycle with that data and return to IDLE.
REQ-027 mem_rvalid_i SHALL be ignored in IDLE and in ISSUE before mem_yumi_i.
REQ-028 A 16-bit cycle counter SHALL clear on entering ISSUE and increment each cycle in ISSUE or WAIT_RESP.
REQ-029 When the counter reaches TIMEOUT_P without completion, SHALL set timeout_o, pulse resp_valid_o[grant] with resp_data_o = 32'hDEAD_BEEF, deassert mem_valid_o and return to IDLE.
REQ-030 Completion in the same cycle the counter reaches TIMEOUT_P SHALL take priority over abort.
REQ-031 Minimum latency SHALL be: read yumi cycle N, mem_valid_o N+1, resp_valid_o N+3 when memory returns one cycle after yumi.
REQ-032 A new grant MAY occur in the same cycle resp_valid_o pulses, since the FSM is then in IDLE.

Reset
REQ-033 On reset, state SHALL = IDLE and last_grant_r = 1, so core 0 wins the first tie.
REQ-034 On reset, counter = 0, timeout_o = 0, and all outputs 0.
REQ-035 Reset mid-transaction SHALL drop the transaction with no resp_valid_o pulse; timeout_o is cleared only by reset.

Structure
REQ-036 SHALL place the arb_state_e enum and the abort data constant (32'hDEAD_BEEF) in the shared definitions package.
REQ-037 SHALL use one sub-module, rr_arb2: 2-input round-robin grant from a valid vector and last grant.

Verification
REQ-038 Verify: core 0 reads 0x100, memory yumis at once and returns 0xCAFE0001 next cycle -> resp_valid_o = 01 three cycles after yumi, resp_data_o = 0xCAFE0001.
REQ-039 Verify: both cores valid from reset -> core 0 granted first, then core 1, then core 0 (alternation over 6 transactions).
REQ-040 Verify: core 1 writes be = 4'b0011, memory holds mem_yumi_i low 5 cycles -> mem_* fields stable for 6 cycles, one resp_valid_o = 10 after yumi.
REQ-041 Verify: read with mem_rvalid_i never asserted, TIMEOUT_P = 8 -> resp_data_o = 0xDEADBEEF 8 cycles after ISSUE entry, timeout_o stays 1.
REQ-042 Verify: reset pulsed while in WAIT_RESP -> all outputs 0 next cycle, no resp_valid_o, next tie granted to core 0.
REQ-043 Verify: mem_rvalid_i asserted in the same cycle as mem_yumi_i on a read -> resp_valid_o next cycle, WAIT_RESP never visited.
